// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage MIPS core.
// Merges per-stage stall requests into a contiguous stall vector
// (bit 0 = PC ... bit 5 = WB) and converts MEM-stage exceptions/eret into a
// one-cycle flush with a redirect PC, deferring the redirect while an
// instruction fetch is still outstanding.
// Optional feature macro: PIPE_CTRL_PERF_EN builds the stall/flush
// performance counters; without it both counter outputs are tied to zero.
module pipe_ctrl #(
  parameter logic [31:0] EXC_BASE = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [31:0] EXC_ERET = 32'h0000000e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        exc_s;
  logic [31:0] target_s;

  // Exception decode: any nonzero code is an event; eret returns to EPC.
  always_comb begin
    exc_s    = (excepttype_i != 32'd0);
    if (excepttype_i == EXC_ERET) begin
      target_s = cp0_epc_i;
    end else begin
      target_s = EXC_BASE;
    end
  end

  // Next-state and Mealy outputs; reset forces the outputs quiet.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = 32'd0;
    case (state_q)
      ST_RUN: begin
        if (stallreq_mem) begin
          // MEM is frozen and keeps presenting any exception until it drains.
          stall = 6'b011111;
        end else if (exc_s && !stallreq_if) begin
          flush  = 1'b1;
          new_pc = target_s;
        end else if (exc_s) begin
          stall     = 6'b111111;
          pend_pc_d = target_s;
          state_d   = ST_PEND;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end else begin
          stall = 6'b000000;
        end
      end
      ST_PEND: begin
        stall = 6'b111111;
        if (!stallreq_if) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        new_pc  = pend_pc_q;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'd0;
    end else begin
      stall  = stall;
      flush  = flush;
      new_pc = new_pc;
    end
  end

  // FSM state and latched redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Counter increments; natural wrap at the counter width.
  always_comb begin
    if (stall[0]) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush) begin
      flush_count_d = flush_count_q + 16'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule
